fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of {PC, instruction} entries held; power of two, at least 2.
REQ-002 Parameter: NOP_INSTR, 32'h00000013, instruction value presented on out_instr while the queue is empty.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch stage presents an entry this cycle.
REQ-006 in_pc  input  64  PC of the presented instruction.
REQ-007 in_instr  input  32  fetched instruction word.
REQ-008 in_ready  output  1  queue can accept an entry this cycle.
REQ-009 out_valid  output  1  head entry is valid for the decode stage.
REQ-010 out_pc  output  64  PC of the head entry.
REQ-011 out_instr  output  32  instruction of the head entry.
REQ-012 out_ready  input  1  decode stage consumes the head entry this cycle.
REQ-013 flush  input  1  branch-taken or redirect; discard all held entries.
REQ-014 count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries, each holding {pc[63:0], instr[31:0]}, with write and read pointers of log2(DEPTH) bits.
REQ-016 Push SHALL occur on a clock edge where in_valid=1, in_ready=1 and flush=0; the entry is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-017 Pop SHALL occur on a clock edge where out_valid=1, out_ready=1 and flush=0; the read pointer increments modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH), combinationally, and SHALL be independent of out_ready; no push is accepted when the queue is full, even if a pop occurs in the same cycle.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 out_pc and out_instr SHALL show the entry at the read pointer when count != 0.
REQ-021 When count = 0, out_pc SHALL be 64'd0 and out_instr SHALL be NOP_INSTR.
REQ-022 Latency: an entry pushed at edge N SHALL appear at the outputs after edge N; there is no same-cycle bypass from in_* to out_*.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 count SHALL increment on a push-only edge, decrement on a pop-only edge, and hold otherwise.
REQ-025 flush=1 at an edge SHALL:
  - set count to 0;
  - set both pointers to 0;
  - discard any concurrent push or pop.
  As a result, out_valid=0 and in_ready=1 after that edge.
REQ-026 in_valid while in_ready=0 SHALL be ignored without corrupting state; the fetch stage is responsible for holding its PC.
REQ-027 Pointer wrap-around SHALL be seamless; FIFO order is preserved across the DEPTH-1 to 0 transition.
REQ-028 in_pc and in_instr SHALL be stored unmodified; no alignment check or decoding occurs in this block.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for clk, force:
  - count=0;
  - both pointers=0;
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR;
  - in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all held entries; storage contents need not be cleared.
REQ-031 After reset deasserts, the first push SHALL be accepted on the next clk rising edge.

Verification
REQ-032 Reset then idle: out_valid=0, out_instr=32'h00000013, out_pc=0, count=0, in_ready=1.
REQ-033 Fill and drain order:
  - push PCs 0x0, 0x4, 0x8, 0xC with out_ready=0 -> count=4, in_ready=0, and a fifth push (PC 0x10) is dropped;
  - then set out_ready=1 -> outputs show PCs 0x0, 0x4, 0x8, 0xC in order on successive cycles, then out_valid=0.
REQ-034 Streaming with wrap-around: continuous push and pop of PCs 0x0..0x3C -> count stays at 1 after the first edge, and the sequence out_pc = 0x0, 0x4, ..., 0x3C is observed without gaps across pointer wrap.
REQ-035 Flush with a concurrent push:
  - hold 3 entries and drive flush=1 with in_valid=1 (PC 0x100) -> count=0 and out_valid=0 after the edge;
  - next push of PC 0x200 -> out_pc=0x200.
REQ-036 Asynchronous reset mid-stream: assert reset between clock edges while count=2 -> count=0 and out_valid=0 before the next clk edge.
REQ-037 Pop from empty: out_ready=1 with count=0 -> no pointer change, and a subsequent push of PC 0x40 appears as out_pc=0x40.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} entries with flush support.
// Outputs show only registered state; there is no bypass from the fetch side to decode.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [63:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // in_ready deliberately ignores out_ready: a full queue never accepts, even while popping.
    assign in_ready  = (count_q < CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = pc_mem[rd_ptr_q];
            out_instr = instr_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected entries on accepted pushes,
// a negedge monitor compares the DUT head/status against the queue and retires popped entries.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hA000_0000 ^ pc[31:0];
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: status and head checked against the scoreboard, then retire on handshake.
    always @(negedge clk) begin
        check("mon_count", 96'(count), 96'(exp_q.size()));
        check("mon_out_valid", 96'(out_valid), 96'(exp_q.size() != 0));
        check("mon_in_ready", 96'(in_ready), 96'(exp_q.size() < DEPTH));
        if (exp_q.size() != 0) begin
            check("mon_head", {out_pc, out_instr}, exp_q[0]);
            if (out_ready && !flush && !reset) void'(exp_q.pop_front());
        end else begin
            check("mon_empty_pc", 96'(out_pc), 96'd0);
            check("mon_empty_instr", 96'(out_instr), 96'(NOP));
        end
    end

    // One cycle of stimulus; acceptance decided from the bench's own occupancy.
    task automatic step(input logic iv, input logic [63:0] pc, input logic ordy, input logic fl);
        logic acc;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
        acc = iv && !fl && (exp_q.size() < DEPTH);
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back({pc, instr_of(pc)});
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_count", 96'(count), 96'd0);
        check("rst_out_valid", 96'(out_valid), 96'd0);
        check("rst_out_pc", 96'(out_pc), 96'd0);
        check("rst_out_instr", 96'(out_instr), 96'h13);
        check("rst_in_ready", 96'(in_ready), 96'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // Fill to full; fifth push must be dropped.
        for (int i = 0; i < 5; i++) step(1'b1, 64'(4 * i), 1'b0, 1'b0);
        check("fill_count", 96'(count), 96'd4);
        check("fill_in_ready", 96'(in_ready), 96'd0);
        check("fill_head_pc", 96'(out_pc), 96'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
        check("drain_out_valid", 96'(out_valid), 96'd0);
        check("drain_count", 96'(count), 96'd0);

        // Streaming across several pointer wraps.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 64'(4 * i), 1'b1, 1'b0);
            check("stream_count", 96'(count), 96'd1);
            check("stream_pc", 96'(out_pc), 96'(4 * i));
        end
        step(1'b0, 64'h0, 1'b1, 1'b0);
        check("stream_end_valid", 96'(out_valid), 96'd0);

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) step(1'b1, 64'h80 + 64'(4 * i), 1'b0, 1'b0);
        check("pre_flush_count", 96'(count), 96'd3);
        step(1'b1, 64'h100, 1'b1, 1'b1);
        check("flush_count", 96'(count), 96'd0);
        check("flush_out_valid", 96'(out_valid), 96'd0);
        check("flush_in_ready", 96'(in_ready), 96'd1);
        step(1'b1, 64'h200, 1'b0, 1'b0);
        check("post_flush_pc", 96'(out_pc), 96'h200);
        check("post_flush_instr", 96'(out_instr), 96'(instr_of(64'h200)));
        step(1'b0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with two entries held.
        step(1'b1, 64'h500, 1'b0, 1'b0);
        step(1'b1, 64'h504, 1'b0, 1'b0);
        check("pre_rst_count", 96'(count), 96'd2);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_count", 96'(count), 96'd0);
        check("async_rst_valid", 96'(out_valid), 96'd0);
        check("async_rst_instr", 96'(out_instr), 96'h13);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1, 64'h300, 1'b0, 1'b0);
        check("post_rst_push_pc", 96'(out_pc), 96'h300);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        // Pop from empty, then a push must surface normally.
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        check("empty_pop_count", 96'(count), 96'd0);
        step(1'b1, 64'h40, 1'b0, 1'b0);
        check("empty_pop_push_pc", 96'(out_pc), 96'h40);
        check("empty_pop_push_count", 96'(count), 96'd1);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        check("final_scoreboard_empty", 96'(exp_q.size()), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
